// File: rtl/sema_pkg.sv
// Shared definitions for the hardware semaphore unit: sizes, FSM states
// and the per-core operation encoding.
package sema_pkg;

    localparam int N_CORE    = 2;
    localparam int N_SEMA    = 16;
    localparam int SEMA_ID_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RESP  = 2'd2
    } sema_fsm_e;

    localparam logic OP_TAS = 1'b0;
    localparam logic OP_REL = 1'b1;

endpackage

// File: rtl/sema_rr_arbiter.sv
// Two-requester round-robin arbiter with a 1-bit priority pointer that only
// moves when both cores contend and a grant is actually taken.
module sema_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_reg;
    logic ptr_next;

    always_comb begin
        grant    = req;
        ptr_next = ptr_reg;
        if (req == 2'b11) begin
            grant = ptr_reg ? 2'b10 : 2'b01;
            // Hand priority to the core that just lost.
            if (advance) begin
                ptr_next = ~ptr_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/sema_unit.sv
// Shared test-and-set / release semaphore block for two cores. One op is in
// flight at a time: IDLE grants and latches, SERVE updates, RESP acknowledges.
module sema_unit #(
    parameter int N_CORE = 2,
    parameter int N_SEMA = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_CORE-1:0]                     sema_req,
    input  logic [N_CORE-1:0]                     sema_we,
    input  logic [N_CORE*sema_pkg::SEMA_ID_W-1:0] sema_id,
    output logic [N_CORE-1:0]                     sema_ack,
    output logic [N_CORE-1:0]                     sema_read_performed,
    output logic [N_CORE-1:0]                     sema_writeback,
    output logic [N_CORE-1:0]                     sema_err,
    output logic [N_SEMA-1:0]                     sema_state
);

    import sema_pkg::*;

    sema_fsm_e state_reg;
    sema_fsm_e state_next;

    logic [N_CORE-1:0]    grant;
    logic                 grant_idx;
    logic                 advance;
    logic                 serve;

    logic                 gnt_core_reg;
    logic                 op_reg;
    logic [SEMA_ID_W-1:0] id_reg;
    logic [N_CORE-1:0]    gnt_vec;

    logic [N_SEMA-1:0]    bits_reg;
    logic [N_SEMA-1:0]    bits_next;
    logic [N_SEMA-1:0]    owner_reg;
    logic [N_SEMA-1:0]    owner_next;
    logic                 old_bit;
    logic                 rel_ok;

    logic [N_CORE-1:0]    ack_reg;
    logic [N_CORE-1:0]    rd_reg;
    logic [N_CORE-1:0]    wb_reg;
    logic [N_CORE-1:0]    err_reg;

    assign advance   = (state_reg == ST_IDLE) && (|sema_req);
    assign serve     = (state_reg == ST_SERVE);
    assign grant_idx = grant[1];

    sema_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (sema_req),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (|sema_req) state_next = ST_SERVE;
            ST_SERVE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The op is captured at grant so later changes on we/id are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_core_reg <= 1'b0;
            op_reg       <= OP_TAS;
            id_reg       <= '0;
        end else if (advance) begin
            gnt_core_reg <= grant_idx;
            op_reg       <= sema_we[grant_idx];
            id_reg       <= sema_id[32'(grant_idx) * SEMA_ID_W +: SEMA_ID_W];
        end
    end

    assign old_bit = bits_reg[id_reg];
    assign rel_ok  = old_bit && (owner_reg[id_reg] == gnt_core_reg);

    genvar gi;
    generate
        for (gi = 0; gi < N_SEMA; gi++) begin : g_sema
            logic hit;
            assign hit = serve && (id_reg == SEMA_ID_W'(gi));
            assign bits_next[gi] = !hit               ? bits_reg[gi] :
                                   (op_reg == OP_TAS) ? 1'b1 :
                                   rel_ok             ? 1'b0 : bits_reg[gi];
            // Ownership is only taken by the TAS that finds the bit free.
            assign owner_next[gi] = (hit && (op_reg == OP_TAS) && !bits_reg[gi]) ?
                                    gnt_core_reg : owner_reg[gi];
        end

        for (gi = 0; gi < N_CORE; gi++) begin : g_core
            assign gnt_vec[gi] = (gnt_core_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_reg  <= '0;
            owner_reg <= '0;
        end else begin
            bits_reg  <= bits_next;
            owner_reg <= owner_next;
        end
    end

    // Responses are registered on the SERVE edge, so they are high exactly in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg <= '0;
            rd_reg  <= '0;
            wb_reg  <= '0;
            err_reg <= '0;
        end else begin
            ack_reg <= serve ? gnt_vec : '0;
            rd_reg  <= (serve && (op_reg == OP_TAS)) ? gnt_vec : '0;
            wb_reg  <= (serve && old_bit) ? gnt_vec : '0;
            err_reg <= (serve && (op_reg == OP_REL) && !rel_ok) ? gnt_vec : '0;
        end
    end

    assign sema_ack            = ack_reg;
    assign sema_read_performed = rd_reg;
    assign sema_writeback      = wb_reg;
    assign sema_err            = err_reg;
    assign sema_state          = bits_reg;

endmodule

// File: tb/tb_sema_unit.sv
// Scoreboard bench for sema_unit: a small semaphore/arbiter model predicts each
// response when stimulus is driven; a negedge monitor pops and compares on ack.
module tb_sema_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sema_req = 2'b00;
    logic [1:0]  sema_we = 2'b00;
    logic [7:0]  sema_id = 8'h00;
    logic [1:0]  sema_ack;
    logic [1:0]  sema_read_performed;
    logic [1:0]  sema_writeback;
    logic [1:0]  sema_err;
    logic [15:0] sema_state;

    always #5 clk = ~clk;

    sema_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .sema_req            (sema_req),
        .sema_we             (sema_we),
        .sema_id             (sema_id),
        .sema_ack            (sema_ack),
        .sema_read_performed (sema_read_performed),
        .sema_writeback      (sema_writeback),
        .sema_err            (sema_err),
        .sema_state          (sema_state)
    );

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  rd;
        logic [1:0]  wb;
        logic [1:0]  err;
        logic [15:0] state;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] m_bits = '0;
    logic [15:0] m_owner = '0;
    logic        m_ptr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits  = '0;
        m_owner = '0;
        m_ptr   = 1'b0;
        exp_q.delete();
    endtask

    // Semaphore model: computes the response and applies the state change.
    task automatic predict(input logic core, input logic we, input logic [3:0] id);
        exp_t e;
        logic old;
        old     = m_bits[id];
        e.ack   = 2'b01 << core;
        e.rd    = we ? 2'b00 : e.ack;
        e.wb    = old ? e.ack : 2'b00;
        e.err   = 2'b00;
        if (!we) begin
            if (!old) begin
                m_bits[id]  = 1'b1;
                m_owner[id] = core;
            end
        end else if (old && (m_owner[id] == core)) begin
            m_bits[id] = 1'b0;
        end else begin
            e.err = e.ack;
        end
        e.state = m_bits;
        exp_q.push_back(e);
        $display("op core%0d %s id %0d -> wb %0b err %0b state %04h",
                 core, we ? "REL" : "TAS", id, old, e.err[core], m_bits);
    endtask

    logic [1:0] prev_ack = 2'b00;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 2'b00;
        end else begin
            if ((prev_ack != 2'b00) && (sema_ack == 2'b00)) begin
                check_eq("resp_cleared",
                         {sema_read_performed, sema_writeback, sema_err}, 6'b0);
            end else if (prev_ack != 2'b00) begin
                check_eq("ack_one_cycle", sema_ack, 2'b00);
            end
            if (sema_ack != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ack", sema_ack, 2'b00);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("ack", sema_ack, mon_e.ack);
                    check_eq("read_performed", sema_read_performed, mon_e.rd);
                    check_eq("writeback", sema_writeback, mon_e.wb);
                    check_eq("err", sema_err, mon_e.err);
                    check_eq("state", sema_state, mon_e.state);
                end
            end
            prev_ack = sema_ack;
        end
    end

    // Issue one op per requesting core; both-requests order follows the model pointer.
    task automatic run_pair(input logic [1:0] reqs, input logic we0, input logic [3:0] id0,
                            input logic we1, input logic [3:0] id1);
        int         cyc;
        int         n_ack;
        logic [1:0] pend;
        if (reqs == 2'b11) begin
            if (!m_ptr) begin
                predict(1'b0, we0, id0);
                predict(1'b1, we1, id1);
            end else begin
                predict(1'b1, we1, id1);
                predict(1'b0, we0, id0);
            end
            m_ptr = ~m_ptr;
        end else if (reqs[0]) begin
            predict(1'b0, we0, id0);
        end else begin
            predict(1'b1, we1, id1);
        end
        sema_we  = {we1, we0};
        sema_id  = {id1, id0};
        sema_req = reqs;
        pend     = reqs;
        cyc      = 0;
        n_ack    = 0;
        while ((pend != 2'b00) && (cyc < 20)) begin
            @(negedge clk);
            cyc++;
            if ((cyc == 1) && (reqs != 2'b11)) begin
                sema_we = ~sema_we;
                sema_id = ~sema_id;
            end
            if (sema_ack != 2'b00) begin
                n_ack++;
                if (n_ack == 1) check_eq("latency_first", cyc, 2);
                else            check_eq("latency_second", cyc, 5);
                pend     = pend & ~sema_ack;
                sema_req = pend;
            end
        end
        if (pend != 2'b00) check_eq("ack_timeout", pend, 2'b00);
        sema_req = 2'b00;
        @(negedge clk);
    endtask

    task automatic run_b2b();
        int cyc;
        int last;
        int k;
        predict(1'b0, 1'b0, 4'd0);
        predict(1'b0, 1'b0, 4'd1);
        predict(1'b0, 1'b0, 4'd2);
        sema_we  = 2'b00;
        sema_id  = 8'h00;
        sema_req = 2'b01;
        k = 0; cyc = 0; last = 0;
        while ((k < 3) && (cyc < 30)) begin
            @(negedge clk);
            cyc++;
            if (sema_ack[0]) begin
                if (k == 0) check_eq("b2b_first", cyc, 2);
                else        check_eq("b2b_gap", cyc - last, 3);
                last = cyc;
                k++;
                sema_id = {4'h0, 4'(k)};
                if (k == 3) sema_req = 2'b00;
            end
        end
        if (k < 3) check_eq("b2b_timeout", k, 3);
        sema_req = 2'b00;
        @(negedge clk);
    endtask

    task automatic run_abort();
        sema_we  = 2'b00;
        sema_id  = 8'h07;
        sema_req = 2'b01;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_ack", sema_ack, 2'b00);
        rst      = 1'b0;
        sema_req = 2'b00;
        model_reset();
        repeat (4) @(negedge clk);
        check_eq("abort_state", sema_state, 16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ack", sema_ack, 2'b00);
        check_eq("rst_rd", sema_read_performed, 2'b00);
        check_eq("rst_wb", sema_writeback, 2'b00);
        check_eq("rst_err", sema_err, 2'b00);
        check_eq("rst_state", sema_state, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        run_pair(2'b01, 1'b0, 4'd3, 1'b0, 4'd0);   // core0 TAS 3 on free sema
        run_pair(2'b10, 1'b0, 4'd0, 1'b0, 4'd3);   // core1 TAS 3, already held
        run_pair(2'b10, 1'b0, 4'd0, 1'b1, 4'd3);   // core1 release of core0's sema
        run_pair(2'b01, 1'b1, 4'd3, 1'b0, 4'd0);   // owner release
        run_pair(2'b01, 1'b1, 4'd3, 1'b0, 4'd0);   // release of a free sema
        run_pair(2'b10, 1'b0, 4'd0, 1'b0, 4'd12);
        run_pair(2'b10, 1'b0, 4'd0, 1'b1, 4'd12);

        do_reset();
        run_pair(2'b11, 1'b0, 4'd5, 1'b0, 4'd5);
        run_pair(2'b11, 1'b0, 4'd6, 1'b0, 4'd6);
        run_pair(2'b11, 1'b0, 4'd10, 1'b0, 4'd10);

        run_abort();
        run_pair(2'b11, 1'b0, 4'd9, 1'b0, 4'd9);

        do_reset();
        run_b2b();
        run_pair(2'b11, 1'b1, 4'd1, 1'b0, 4'd1);
        run_pair(2'b11, 1'b1, 4'd15, 1'b0, 4'd15);

        repeat (3) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
